// File: rtl/mult_block_buffer_pkg.sv
// mult_buf_pkg: shared types and helpers for the multiply block buffer.
//   state_t        - controller states (IDLE, FILL, DRAIN, FULL, READ)
//   map_block_len  - converts the block_len port encoding into an entry count
package mult_buf_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      FILL  = 3'd1,
      DRAIN = 3'd2,
      FULL  = 3'd3,
      READ  = 3'd4
   } state_t;

   // A block length of zero encodes the full memory depth.
   function automatic logic [31:0] map_block_len(input logic [31:0] len,
                                                 input int unsigned logdepth);
      logic [31:0] n_v;
      if (len == 32'd0) begin
         n_v = 32'd1 << logdepth;
      end else begin
         n_v = len;
      end
      return n_v;
   endfunction

endpackage

// File: rtl/mult_pipe.sv
// mult_pipe: MULT_LAT-stage signed/unsigned multiplier carrying a valid bit
// and a memory address alongside each product.
//   clk, rst (async, active-low)
//   in_valid, in_a, in_b, signed_mode, in_addr : operand side
//   out_valid, out_addr, out_val               : registered write side
module mult_pipe
   import mult_buf_pkg::*;
#(
   parameter int IN_WIDTH = 16,
   parameter int WIDTH    = 32,
   parameter int LOGDEPTH = 6,
   parameter int MULT_LAT = 2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   input  logic [IN_WIDTH-1:0] in_a,
   input  logic [IN_WIDTH-1:0] in_b,
   input  logic                signed_mode,
   input  logic [LOGDEPTH-1:0] in_addr,
   output logic                out_valid,
   output logic [LOGDEPTH-1:0] out_addr,
   output logic [WIDTH-1:0]    out_val
);

   localparam int EXT_W = WIDTH - IN_WIDTH;

   generate
      if (MULT_LAT < 1) begin : g_lat_chk
         $error("mult_pipe: MULT_LAT must be at least 1");
      end
   endgenerate

   logic [WIDTH-1:0]    a_ext_s;
   logic [WIDTH-1:0]    b_ext_s;
   logic [WIDTH-1:0]    prod_s;
   logic                vld_r  [MULT_LAT];
   logic [LOGDEPTH-1:0] addr_r [MULT_LAT];
   logic [WIDTH-1:0]    val_r  [MULT_LAT];

   // Extend operands to the product width; the low WIDTH bits of the
   // extended product are exact because WIDTH >= 2*IN_WIDTH.
   always_comb begin
      if (signed_mode) begin
         a_ext_s = {{EXT_W{in_a[IN_WIDTH-1]}}, in_a};
         b_ext_s = {{EXT_W{in_b[IN_WIDTH-1]}}, in_b};
      end else begin
         a_ext_s = {{EXT_W{1'b0}}, in_a};
         b_ext_s = {{EXT_W{1'b0}}, in_b};
      end
      prod_s = a_ext_s * b_ext_s;
   end

   // Shift pipeline; data stages only load behind a valid bit.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < MULT_LAT; i++) begin
            vld_r[i]  <= 1'b0;
            addr_r[i] <= '0;
            val_r[i]  <= '0;
         end
      end else begin
         vld_r[0] <= in_valid;
         if (in_valid) begin
            addr_r[0] <= in_addr;
            val_r[0]  <= prod_s;
         end
         for (int i = 1; i < MULT_LAT; i++) begin
            vld_r[i] <= vld_r[i-1];
            if (vld_r[i-1]) begin
               addr_r[i] <= addr_r[i-1];
               val_r[i]  <= val_r[i-1];
            end
         end
      end
   end

   assign out_valid = vld_r[MULT_LAT-1];
   assign out_addr  = addr_r[MULT_LAT-1];
   assign out_val   = val_r[MULT_LAT-1];

endmodule

// File: rtl/mult_block_buffer.sv
// mult_block_buffer: accepts a block of N operand pairs, writes their
// products to an external memory at addresses 0..N-1, then streams the
// block back out of the memory on request.
//   clk, rst (async, active-low)
//   EN_mult, mult_input0/1, signed_mode, block_len, RDY_mult : operand side
//   EN_writeMem, writeMem_addr, writeMem_val                 : memory write
//   EN_blockRead, EN_readMem, readMem_addr, readMem_val      : memory read
//   VALID_memVal, memVal_data, memVal_last                   : read stream
module mult_block_buffer
   import mult_buf_pkg::*;
#(
   parameter int IN_WIDTH = 16,
   parameter int WIDTH    = 32,
   parameter int LOGDEPTH = 6,
   parameter int MULT_LAT = 2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                EN_mult,
   input  logic [IN_WIDTH-1:0] mult_input0,
   input  logic [IN_WIDTH-1:0] mult_input1,
   input  logic                signed_mode,
   input  logic [LOGDEPTH:0]   block_len,
   output logic                RDY_mult,
   output logic                EN_writeMem,
   output logic [LOGDEPTH-1:0] writeMem_addr,
   output logic [WIDTH-1:0]    writeMem_val,
   input  logic                EN_blockRead,
   output logic                EN_readMem,
   output logic [LOGDEPTH-1:0] readMem_addr,
   input  logic [WIDTH-1:0]    readMem_val,
   output logic                VALID_memVal,
   output logic [WIDTH-1:0]    memVal_data,
   output logic                memVal_last
);

   localparam int CNT_W = LOGDEPTH + 1;

   generate
      if (WIDTH < 2 * IN_WIDTH) begin : g_width_chk
         $error("mult_block_buffer: WIDTH must be >= 2*IN_WIDTH");
      end
   endgenerate

   state_t              state_r;
   logic [CNT_W-1:0]    n_r;
   logic [CNT_W-1:0]    acc_cnt_r;
   logic [CNT_W-1:0]    rd_cnt_r;
   logic                mode_r;
   logic                accept_s;
   logic                mode_s;
   logic [CNT_W-1:0]    n_in_s;
   logic [LOGDEPTH-1:0] last_addr_s;
   logic [LOGDEPTH-1:0] wr_addr_s;

   // Ready decode, operand acceptance and per-block parameter selection.
   // The first operand of a block uses the live mode; later ones the latched.
   always_comb begin
      case (state_r)
         IDLE:    RDY_mult = 1'b1;
         FILL:    RDY_mult = (acc_cnt_r < n_r);
         default: RDY_mult = 1'b0;
      endcase
      accept_s = EN_mult && RDY_mult;
      if (state_r == IDLE) begin
         mode_s = signed_mode;
      end else begin
         mode_s = mode_r;
      end
      n_in_s      = CNT_W'(map_block_len(32'(block_len), LOGDEPTH));
      last_addr_s = LOGDEPTH'(n_r - CNT_W'(1));
      wr_addr_s   = LOGDEPTH'(acc_cnt_r);
   end

   mult_pipe #(
      .IN_WIDTH (IN_WIDTH),
      .WIDTH    (WIDTH),
      .LOGDEPTH (LOGDEPTH),
      .MULT_LAT (MULT_LAT)
   ) u_mult_pipe (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (accept_s),
      .in_a        (mult_input0),
      .in_b        (mult_input1),
      .signed_mode (mode_s),
      .in_addr     (wr_addr_s),
      .out_valid   (EN_writeMem),
      .out_addr    (writeMem_addr),
      .out_val     (writeMem_val)
   );

   assign memVal_data = readMem_val;

   // Block controller with registered read-side outputs. The valid beat
   // trails each read enable by one cycle to match the memory latency.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r      <= IDLE;
         n_r          <= '0;
         acc_cnt_r    <= '0;
         rd_cnt_r     <= '0;
         mode_r       <= 1'b0;
         EN_readMem   <= 1'b0;
         readMem_addr <= '0;
         VALID_memVal <= 1'b0;
         memVal_last  <= 1'b0;
      end else begin
         EN_readMem   <= 1'b0;
         VALID_memVal <= EN_readMem;
         memVal_last  <= EN_readMem && (readMem_addr == last_addr_s);
         case (state_r)
            IDLE: begin
               if (accept_s) begin
                  n_r       <= n_in_s;
                  mode_r    <= signed_mode;
                  acc_cnt_r <= CNT_W'(1);
                  state_r   <= (n_in_s == CNT_W'(1)) ? DRAIN : FILL;
               end
            end
            FILL: begin
               if (accept_s) begin
                  acc_cnt_r <= acc_cnt_r + CNT_W'(1);
                  if (acc_cnt_r + CNT_W'(1) == n_r) begin
                     state_r <= DRAIN;
                  end
               end
            end
            DRAIN: begin
               // Writes leave the pipe in address order, so the last
               // address marks the end of the block.
               if (EN_writeMem && (writeMem_addr == last_addr_s)) begin
                  state_r <= FULL;
               end
            end
            FULL: begin
               if (EN_blockRead) begin
                  rd_cnt_r <= '0;
                  state_r  <= READ;
               end
            end
            READ: begin
               if (EN_blockRead && (rd_cnt_r < n_r)) begin
                  EN_readMem   <= 1'b1;
                  readMem_addr <= LOGDEPTH'(rd_cnt_r);
                  rd_cnt_r     <= rd_cnt_r + CNT_W'(1);
               end
               if (memVal_last) begin
                  acc_cnt_r <= '0;
                  rd_cnt_r  <= '0;
                  state_r   <= IDLE;
               end
            end
            default: begin
               state_r <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mult_block_buffer.sv
// tb_mult_block_buffer: directed stimulus with a cycle-level reference
// model of the block buffer; the bench also acts as the external memory.
module tb_mult_block_buffer;

   localparam int IN_WIDTH = 16;
   localparam int WIDTH    = 32;
   localparam int LOGDEPTH = 6;
   localparam int MULT_LAT = 2;
   localparam int DEPTH    = 64;

   logic                clk;
   logic                rst;
   logic                EN_mult;
   logic [IN_WIDTH-1:0] mult_input0;
   logic [IN_WIDTH-1:0] mult_input1;
   logic                signed_mode;
   logic [LOGDEPTH:0]   block_len;
   logic                RDY_mult;
   logic                EN_writeMem;
   logic [LOGDEPTH-1:0] writeMem_addr;
   logic [WIDTH-1:0]    writeMem_val;
   logic                EN_blockRead;
   logic                EN_readMem;
   logic [LOGDEPTH-1:0] readMem_addr;
   logic [WIDTH-1:0]    readMem_val;
   logic                VALID_memVal;
   logic [WIDTH-1:0]    memVal_data;
   logic                memVal_last;

   mult_block_buffer #(
      .IN_WIDTH (IN_WIDTH),
      .WIDTH    (WIDTH),
      .LOGDEPTH (LOGDEPTH),
      .MULT_LAT (MULT_LAT)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .EN_mult       (EN_mult),
      .mult_input0   (mult_input0),
      .mult_input1   (mult_input1),
      .signed_mode   (signed_mode),
      .block_len     (block_len),
      .RDY_mult      (RDY_mult),
      .EN_writeMem   (EN_writeMem),
      .writeMem_addr (writeMem_addr),
      .writeMem_val  (writeMem_val),
      .EN_blockRead  (EN_blockRead),
      .EN_readMem    (EN_readMem),
      .readMem_addr  (readMem_addr),
      .readMem_val   (readMem_val),
      .VALID_memVal  (VALID_memVal),
      .memVal_data   (memVal_data),
      .memVal_last   (memVal_last)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // External memory with one-cycle synchronous read.
   logic [WIDTH-1:0] mem [DEPTH];
   always @(posedge clk) begin
      if (EN_writeMem) mem[writeMem_addr] <= writeMem_val;
      if (EN_readMem)  readMem_val <= mem[readMem_addr];
   end

   // ---------------- reference model state ----------------
   typedef struct packed {
      int          due;
      int          addr;
      logic [31:0] val;
   } wr_t;

   wr_t         wq[$];
   logic [31:0] exp_mem [DEPTH];
   int          cyc;
   bit          m_active, m_mode, m_full, m_reading;
   int          m_n, m_acc, m_wr, m_rd;
   bit          ren_nx, vld_nx;
   int          raddr_nx, vaddr_nx, m_raddr;

   // observations used by the literal checks
   logic [31:0] seen_val [DEPTH];
   int          seen_writes, seen_beats, seen_lasts;
   int          blk_start_cyc, rdy_low_cyc;

   int n_chk;
   int n_err;

   task automatic chk(input string name, input longint act, input longint exp);
      n_chk++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s cycle=%0d actual=%0h expected=%0h", name, cyc, act, exp);
      end
   endtask

   // Full-precision product from plain integer arithmetic.
   function automatic logic [31:0] model_prod(input logic [15:0] a, input logic [15:0] b,
                                              input bit sgn);
      longint sa, sb, p;
      sa = longint'(a);
      sb = longint'(b);
      if (sgn && a[15]) sa = sa - 65536;
      if (sgn && b[15]) sb = sb - 65536;
      p = sa * sb;
      return 32'(p);
   endfunction

   task automatic model_clear();
      wq.delete();
      m_active  = 1'b0;
      m_full    = 1'b0;
      m_reading = 1'b0;
      m_acc = 0; m_wr = 0; m_rd = 0; m_n = 0;
      ren_nx = 1'b0; vld_nx = 1'b0;
      raddr_nx = 0; vaddr_nx = 0; m_raddr = 0;
   endtask

   // Compare process: mid-cycle check of every output, then model advance.
   always @(negedge clk) begin
      bit exp_w, exp_ren, exp_vld, rdy_exp;
      int exp_vaddr;
      wr_t w;
      if (!rst) begin
         chk("rst_rdy", RDY_mult, 1);
         chk("rst_wr_en", EN_writeMem, 0);
         chk("rst_wr_addr", writeMem_addr, 0);
         chk("rst_wr_val", writeMem_val, 0);
         chk("rst_rd_en", EN_readMem, 0);
         chk("rst_rd_addr", readMem_addr, 0);
         chk("rst_valid", VALID_memVal, 0);
         chk("rst_last", memVal_last, 0);
         model_clear();
      end else begin
         rdy_exp = !m_active || (m_acc < m_n);
         chk("rdy", RDY_mult, rdy_exp);
         exp_w = (wq.size() > 0) && (wq[0].due == cyc);
         chk("wr_en", EN_writeMem, exp_w);
         if (exp_w) begin
            chk("wr_addr", writeMem_addr, wq[0].addr);
            chk("wr_val", writeMem_val, wq[0].val);
         end
         if (EN_writeMem) begin
            seen_writes++;
            seen_val[writeMem_addr] = writeMem_val;
         end
         exp_ren = ren_nx;
         if (exp_ren) m_raddr = raddr_nx;
         chk("rd_en", EN_readMem, exp_ren);
         chk("rd_addr", readMem_addr, m_raddr);
         exp_vld   = vld_nx;
         exp_vaddr = vaddr_nx;
         chk("valid", VALID_memVal, exp_vld);
         chk("last", memVal_last, exp_vld && (exp_vaddr == m_n - 1));
         if (exp_vld) chk("data", memVal_data, exp_mem[exp_vaddr]);
         if (VALID_memVal) seen_beats++;
         if (memVal_last)  seen_lasts++;
         if (m_active && rdy_low_cyc < 0 && !RDY_mult) rdy_low_cyc = cyc - blk_start_cyc;

         // advance model to the next cycle
         vld_nx   = exp_ren;
         vaddr_nx = m_raddr;
         ren_nx   = 1'b0;
         if (m_reading && EN_blockRead && m_rd < m_n) begin
            ren_nx   = 1'b1;
            raddr_nx = m_rd;
            m_rd++;
         end
         if (m_full && !m_reading && EN_blockRead) m_reading = 1'b1;
         if (exp_w) begin
            void'(wq.pop_front());
            m_wr++;
            if (m_wr == m_n) m_full = 1'b1;
         end
         if (exp_vld && exp_vaddr == m_n - 1) begin
            m_active = 1'b0; m_full = 1'b0; m_reading = 1'b0;
            m_acc = 0; m_wr = 0; m_rd = 0;
         end
         if (EN_mult && rdy_exp) begin
            if (!m_active) begin
               m_active      = 1'b1;
               m_n           = (block_len == '0) ? DEPTH : int'(block_len);
               m_mode        = signed_mode;
               blk_start_cyc = cyc;
               rdy_low_cyc   = -1;
            end
            exp_mem[m_acc] = model_prod(mult_input0, mult_input1, m_mode);
            w.due  = cyc + MULT_LAT;
            w.addr = m_acc;
            w.val  = exp_mem[m_acc];
            wq.push_back(w);
            m_acc++;
         end
      end
      cyc++;
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [15:0] a, input logic [15:0] b, input bit sgn);
      EN_mult     = 1'b1;
      mult_input0 = a;
      mult_input1 = b;
      signed_mode = sgn;
      tick();
      EN_mult = 1'b0;
   endtask

   task automatic wait_full(input int budget);
      int k;
      k = 0;
      while (!m_full && k < budget) begin
         tick();
         k++;
      end
      chk("full_timeout", m_full, 1);
   endtask

   task automatic read_all(input int budget);
      int k;
      k = 0;
      EN_blockRead = 1'b1;
      while (m_active && k < budget) begin
         tick();
         k++;
      end
      EN_blockRead = 1'b0;
      chk("read_timeout", m_active, 0);
   endtask

   task automatic clear_seen();
      for (int i = 0; i < DEPTH; i++) seen_val[i] = 32'hDEADBEEF;
      seen_writes = 0;
      seen_beats  = 0;
      seen_lasts  = 0;
   endtask

   initial begin
      int k;
      n_chk = 0; n_err = 0; cyc = 0; rdy_low_cyc = -1; blk_start_cyc = 0;
      rst = 1'b0; EN_mult = 1'b0; mult_input0 = '0; mult_input1 = '0;
      signed_mode = 1'b0; block_len = '0; EN_blockRead = 1'b0; readMem_val = '0;
      model_clear();
      clear_seen();
      tick(); tick(); tick();
      rst = 1'b1;
      tick();

      // 64 unsigned pairs (i, i+1), full-depth block
      clear_seen();
      block_len = '0;
      for (int i = 0; i < DEPTH; i++) send(16'(i), 16'(i + 1), 1'b0);
      wait_full(20);
      chk("lit_rdy_low_cycle", rdy_low_cyc, 64);
      chk("lit_writes64", seen_writes, 64);
      chk("lit_val0", seen_val[0], 0);
      chk("lit_val10", seen_val[10], 110);
      chk("lit_val63", seen_val[63], 4032);
      read_all(200);
      chk("lit_beats64", seen_beats, 64);
      tick();

      // signed block of 4, mode toggled mid-block
      clear_seen();
      block_len = 7'd4;
      send(16'hFFFD, 16'd7, 1'b1);
      send(16'h8000, 16'h8000, 1'b1);
      send(16'd5, 16'hFFFF, 1'b0);
      send(16'd0, 16'd9, 1'b0);
      wait_full(20);
      chk("lit_s0", seen_val[0], 32'hFFFFFFEB);
      chk("lit_s1", seen_val[1], 32'h40000000);
      chk("lit_s2", seen_val[2], 32'hFFFFFFFB);
      chk("lit_s3", seen_val[3], 32'h00000000);
      read_all(40);

      // block of 3 with two-cycle gaps; EN_mult held high while FULL
      clear_seen();
      block_len = 7'd3;
      for (int i = 0; i < 3; i++) begin
         send(16'(10 + i), 16'd3, 1'b0);
         tick();
         tick();
      end
      wait_full(20);
      EN_mult = 1'b1; mult_input0 = 16'd99; mult_input1 = 16'd99;
      tick(); tick(); tick();
      EN_mult = 1'b0;
      tick(); tick(); tick();
      chk("lit_writes3", seen_writes, 3);
      chk("lit_g2", seen_val[2], 36);
      read_all(40);

      // EN_blockRead in IDLE is ignored
      EN_blockRead = 1'b1;
      tick(); tick(); tick();
      EN_blockRead = 1'b0;
      tick();

      // 8-entry block, read paused for 3 cycles after the 4th address
      clear_seen();
      block_len = 7'd8;
      for (int i = 0; i < 8; i++) send(16'(i + 3), 16'(100 - i), 1'b0);
      wait_full(20);
      EN_blockRead = 1'b1;
      k = 0;
      while (m_rd < 4 && k < 20) begin
         tick();
         k++;
      end
      chk("pause_timeout", m_rd, 4);
      EN_blockRead = 1'b0;
      tick(); tick(); tick();
      read_all(40);
      chk("lit_beats8", seen_beats, 8);
      chk("lit_lasts1", seen_lasts, 1);
      tick();

      // reset one cycle after the 10th acceptance
      block_len = '0;
      for (int i = 0; i < 10; i++) send(16'(i + 1), 16'd2, 1'b0);
      rst = 1'b0;
      tick(); tick();
      rst = 1'b1;
      clear_seen();
      for (int i = 0; i < 6; i++) tick();
      chk("lit_no_writes", seen_writes, 0);
      block_len = 7'd2;
      send(16'd3, 16'd4, 1'b0);
      send(16'd5, 16'd6, 1'b0);
      wait_full(20);
      chk("lit_new0", seen_val[0], 12);
      chk("lit_new1", seen_val[1], 30);
      read_all(40);
      tick(); tick();

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

endmodule

// File: doc/mult_block_buffer.md
MULT_BLOCK_BUFFER -- requirements
Module: mult_block_buffer

Interface
REQ-001 Parameter IN_WIDTH, default 16: operand width in bits.
REQ-002 Parameter WIDTH, default 32: product/memory word width; SHALL be >= 2*IN_WIDTH, enforced by an elaboration-time check.
REQ-003 Parameter LOGDEPTH, default 6: memory address width; maximum block is 2**LOGDEPTH entries.
REQ-004 Parameter MULT_LAT, default 2 (minimum 1): cycles from operand acceptance to memory write.
REQ-005 Ports: clk  in  1  single clock, rising edge; rst  in  1  asynchronous, active-low reset.
REQ-006 Operand-side ports:
- EN_mult  in  1  operand valid.
- mult_input0, mult_input1  in  IN_WIDTH  operands.
- signed_mode  in  1  1 = signed (two's complement), 0 = unsigned.
- block_len  in  LOGDEPTH+1  entries per block; 0 means 2**LOGDEPTH.
- RDY_mult  out  1  operand accepted when EN_mult && RDY_mult.
REQ-007 Write-side ports: EN_writeMem  out  1; writeMem_addr  out  LOGDEPTH; writeMem_val  out  WIDTH.
REQ-008 Read-side ports:
- EN_blockRead  in  1  read request and ready.
- EN_readMem  out  1; readMem_addr  out  LOGDEPTH; readMem_val  in  WIDTH  (memory has 1-cycle synchronous read).
- VALID_memVal  out  1; memVal_data  out  WIDTH; memVal_last  out  1.

Function
REQ-009 States SHALL be IDLE, FILL, DRAIN, FULL and READ.
REQ-010 IDLE: RDY_mult=1. On the first accepted operand, latch N (block_len, with 0 mapped to 2**LOGDEPTH) and signed_mode for the whole block. Next state is FILL, or DRAIN if N=1.
REQ-011 FILL: RDY_mult=1 while accepted count < N. EN_mult low creates a bubble and produces no write. After the Nth acceptance, RDY_mult=0 in the next cycle and the state goes to DRAIN.
REQ-012 The k-th accepted operand pair (k=0..N-1) SHALL produce EN_writeMem=1, writeMem_addr=k and writeMem_val=product exactly MULT_LAT cycles after acceptance.
REQ-013 Product arithmetic: when the latched mode is signed, operands are sign-extended to WIDTH and the product is full-precision; when unsigned, operands are zero-extended. There is no truncation because WIDTH >= 2*IN_WIDTH.
REQ-014 DRAIN: RDY_mult=0. Move to FULL in the cycle after write N-1 is issued.
REQ-015 FULL: RDY_mult=0 and EN_mult is ignored. EN_blockRead=1 moves the state to READ.
REQ-016 READ: while EN_blockRead=1, issue one EN_readMem per cycle at readMem_addr 0..N-1 in order. EN_blockRead=0 pauses issue and holds the address.
REQ-017 VALID_memVal SHALL equal EN_readMem delayed by one cycle. memVal_data=readMem_val. memVal_last=1 with the valid beat for address N-1.
REQ-018 After the memVal_last beat, return to IDLE with RDY_mult=1 in the following cycle.
REQ-019 EN_blockRead outside FULL/READ SHALL be ignored. EN_writeMem and EN_readMem SHALL never be high in the same cycle.
REQ-020 Every output except RDY_mult and memVal_data SHALL be registered. RDY_mult is decoded from state and count.

Reset
REQ-021 rst low SHALL asynchronously force:
- state to IDLE;
- all counters and pipeline valid bits to 0;
- EN_writeMem, writeMem_addr, writeMem_val, EN_readMem, readMem_addr, VALID_memVal and memVal_last to 0.
RDY_mult=1 during reset (IDLE decode).
REQ-022 Reset mid-block SHALL discard in-flight products: no EN_writeMem may occur after rst is deasserted until new operands are accepted.

Structure
REQ-023 Package mult_buf_pkg SHALL hold the state enum (state_t) and the block-length mapping function.
REQ-024 Sub-module mult_pipe SHALL implement the MULT_LAT-stage signed/unsigned multiplier with a matching valid/address shift pipeline.

Verification
REQ-025 Defaults, block_len=0, 64 unsigned pairs (i, i+1) back-to-back -> writes at addr i with val i*(i+1) at MULT_LAT=2; FULL reached; RDY_mult low from cycle 65.
REQ-026 signed_mode=1, block_len=4, operands (-3,7), (-32768,-32768), (5,-1), (0,9) -> values -21, 1073741824, -5, 0; mode held for the block even if toggled mid-block.
REQ-027 block_len=3 with EN_mult gaps of 2 cycles between pairs -> exactly 3 writes at addrs 0,1,2 with no extra writes; DRAIN then FULL.
REQ-028 Read of an 8-entry block with EN_blockRead dropped for 3 cycles after the 4th address -> 8 valid beats in order, no duplicates, memVal_last only on addr 7; back to IDLE.
REQ-029 rst pulled low 1 cycle after the 10th acceptance -> no writes after release; RDY_mult=1; new block starts at addr 0.
REQ-030 EN_mult high in FULL and EN_blockRead high in IDLE -> both ignored; no memory enables asserted.
